// File: rtl/disp_scan_mux.sv
// Multiplexed decimal display scanner.
// A prescaled one-hot digit scan drives the display. A serial double-dabble
// FSM converts every binary field to decimal digit codes in a shadow buffer.
// The FSM then commits the whole shadow buffer to the display buffer in one cycle.
module disp_scan_mux #(
    parameter int N_FIELDS = 2,
    parameter int FIELD_W  = 8,
    parameter int DPF      = 2,
    parameter int DIV      = 8,
    parameter int LZB      = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [N_FIELDS*FIELD_W-1:0]    val,
    input  logic                           blank,
    output logic [N_FIELDS*DPF-1:0]        dig,
    output logic [3:0]                     num,
    output logic                           frame
);

    localparam int ND  = N_FIELDS * DPF;
    // Decimal digits needed to hold any FIELD_W-bit value (ceil(W*log10(2))).
    localparam int NBD = (FIELD_W * 3) / 10 + 1;
    // The accumulator holds at least DPF digits, so overflow can be read from the digits above DPF-1.
    localparam int NBA = (NBD > DPF) ? NBD : DPF;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;
    localparam int FW  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_STORE  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [4*NBA-1:0] f_add3(input logic [4*NBA-1:0] b);
        logic [4*NBA-1:0] r;
        r = b;
        for (int k = 0; k < NBA; k++) begin
            if (b[k*4 +: 4] >= 4'd5) begin
                r[k*4 +: 4] = b[k*4 +: 4] + 4'd3;
            end else begin
                r[k*4 +: 4] = b[k*4 +: 4];
            end
        end
        return r;
    endfunction

    // Turn a finished BCD value into the field's display codes.
    // Overflow shows as dashes. Optional leading-zero blanking never blanks digit 0.
    function automatic logic [4*DPF-1:0] f_codes(input logic [4*NBA-1:0] b);
        logic [4*DPF-1:0] c;
        logic             ovf;
        logic             lead;
        c   = '0;
        ovf = 1'b0;
        for (int k = DPF; k < NBA; k++) begin
            ovf = ovf | (b[k*4 +: 4] != 4'd0);
        end
        lead = (LZB != 0);
        for (int k = DPF - 1; k >= 0; k--) begin
            if (ovf) begin
                c[k*4 +: 4] = 4'hA;
            end else if (lead && (k != 0) && (b[k*4 +: 4] == 4'd0)) begin
                c[k*4 +: 4] = 4'hF;
            end else begin
                c[k*4 +: 4] = b[k*4 +: 4];
                lead        = 1'b0;
            end
        end
        return c;
    endfunction

    state_t                         r_state;
    logic [FW-1:0]                  r_fld;
    logic [CW-1:0]                  r_cnt;
    logic [FIELD_W-1:0]             r_bin;
    logic [4*NBA-1:0]               r_bcd;
    logic [N_FIELDS*FIELD_W-1:0]    r_snap;
    logic [4*ND-1:0]                r_shadow;
    logic [4*ND-1:0]                r_disp;
    logic                           r_valid;
    logic                           r_init;
    logic                           r_blank_d;
    logic [PW-1:0]                  r_pre;

    logic                           w_fall;
    logic                           w_req;
    logic [N_FIELDS*FIELD_W-1:0]    w_src;
    logic [FIELD_W-1:0]             w_load_bin;
    logic [4*NBA-1:0]               w_adj;
    logic                           w_tick;
    logic [PW-1:0]                  w_pre_nxt;
    logic [ND-1:0]                  w_dig_nxt;
    logic                           w_frame_nxt;
    logic [4*ND-1:0]                w_disp_nxt;
    logic                           w_valid_nxt;
    logic [3:0]                     w_num_nxt;

    // Conversion request sources and the field operand selected for LOAD.
    always_comb begin
        w_fall = r_blank_d & ~blank;
        w_req  = r_init | frame | w_fall;
        // Field 0's LOAD takes the snapshot, so it reads val directly.
        if (r_fld == FW'(0)) begin
            w_src = val;
        end else begin
            w_src = r_snap;
        end
        w_load_bin = w_src[0 +: FIELD_W];
        for (int f = 0; f < N_FIELDS; f++) begin
            if (r_fld == FW'(f)) begin
                w_load_bin = w_src[f*FIELD_W +: FIELD_W];
            end else begin
                w_load_bin = w_load_bin;
            end
        end
        w_adj = f_add3(r_bcd);
    end

    // Conversion FSM with its datapath: snapshot, shift-add-3, store, commit.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_fld    <= '0;
            r_cnt    <= '0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_snap   <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_valid  <= 1'b0;
            r_init   <= 1'b1;
        end else begin
            r_init <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_fld <= '0;
                    if (w_req) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (r_fld == FW'(0)) begin
                        r_snap <= val;
                    end else begin
                        r_snap <= r_snap;
                    end
                    r_bin   <= w_load_bin;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[4*NBA-2:0], r_bin[FIELD_W-1]};
                    r_bin <= r_bin << 1;
                    if (r_cnt == CW'(FIELD_W - 1)) begin
                        r_state <= S_STORE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_state <= S_SHIFT;
                    end
                end
                S_STORE: begin
                    for (int f = 0; f < N_FIELDS; f++) begin
                        if (r_fld == FW'(f)) begin
                            r_shadow[f*DPF*4 +: DPF*4] <= f_codes(r_bcd);
                        end else begin
                            r_shadow[f*DPF*4 +: DPF*4] <= r_shadow[f*DPF*4 +: DPF*4];
                        end
                    end
                    if (r_fld == FW'(N_FIELDS - 1)) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_fld   <= r_fld + FW'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_COMMIT: begin
                    r_disp  <= r_shadow;
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Next scan position and the code for that position.
    // num is computed from next-cycle dig and display state, so it lands together with dig.
    always_comb begin
        w_tick = (r_pre == PW'(DIV - 1));
        if (blank) begin
            w_pre_nxt = '0;
            w_dig_nxt = ND'(1);
        end else if (w_tick) begin
            w_pre_nxt = '0;
            w_dig_nxt = (dig << 1) | (dig >> (ND - 1));
        end else begin
            w_pre_nxt = r_pre + PW'(1);
            w_dig_nxt = dig;
        end
        w_frame_nxt = ~blank & w_tick & dig[ND-1];
        if (r_state == S_COMMIT) begin
            w_disp_nxt  = r_shadow;
            w_valid_nxt = 1'b1;
        end else begin
            w_disp_nxt  = r_disp;
            w_valid_nxt = r_valid;
        end
        w_num_nxt = 4'hF;
        for (int i = 0; i < ND; i++) begin
            if (w_dig_nxt[i] && w_valid_nxt && !blank) begin
                w_num_nxt = w_disp_nxt[i*4 +: 4];
            end else begin
                w_num_nxt = w_num_nxt;
            end
        end
    end

    // Scan registers: prescaler, digit enable, digit code, frame pulse, blank edge history.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pre     <= '0;
            dig       <= ND'(1);
            num       <= 4'hF;
            frame     <= 1'b0;
            r_blank_d <= 1'b0;
        end else begin
            r_pre     <= w_pre_nxt;
            dig       <= w_dig_nxt;
            num       <= w_num_nxt;
            frame     <= w_frame_nxt;
            r_blank_d <= blank;
        end
    end

endmodule
